// File: rtl/pipe_fifo_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_fifo_pkg
//  Brief    : Shared constants and pointer helper for the pipe_fifo block.
//  Revision : 1.0 - initial release
// ============================================================================
package pipe_fifo_pkg;

    // Level at which rst asserts; this block resets asynchronously on low.
    localparam logic c_RST_ACTIVE = 1'b0;

    // Explicit compare-and-wrap so non-power-of-two depths index correctly.
    function automatic int unsigned ptr_next(input int unsigned ptr, input int unsigned depth);
        return (ptr == depth - 32'd1) ? 32'd0 : ptr + 32'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_fifo_mem.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_fifo_mem
//  Brief    : DEPTH x DATA_WIDTH register array, one write port, async read.
//  Revision : 1.0 - initial release
// ============================================================================
module pipe_fifo_mem #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 2,
    parameter int ADDR_WIDTH = 1
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    generate
        if (DEPTH == 1) begin : g_single
            logic [DATA_WIDTH-1:0] r_mem;
            logic                  w_unused_addr;

            assign w_unused_addr = ^{waddr, raddr};

            always_ff @(posedge clk) begin
                if (we) r_mem <= wdata;
            end

            assign rdata = r_mem;
        end else begin : g_array
            logic [DATA_WIDTH-1:0] r_mem [DEPTH];

            always_ff @(posedge clk) begin
                if (we) r_mem[waddr] <= wdata;
            end

            assign rdata = r_mem[raddr];
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/pipe_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_fifo
//  Brief    : Elastic valid/ready buffer with optional fall-through, flush,
//             occupancy count and full/empty flags.
//  Revision : 1.0 - initial release
// ============================================================================
module pipe_fifo
    import pipe_fifo_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int DEPTH        = 2,
    parameter int FALL_THROUGH = 0,
    parameter int PASS_READY   = 1,
    parameter int ZERO_INVALID = 1,
    parameter int CNT_WIDTH    = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  pin_valid,
    input  logic [DATA_WIDTH-1:0] pin_data,
    output logic                  pin_ready,
    output logic                  pout_valid,
    output logic [DATA_WIDTH-1:0] pout_data,
    input  logic                  pout_ready,
    output logic [CNT_WIDTH-1:0]  count,
    output logic                  full,
    output logic                  empty
);

    localparam int   c_PTR_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic c_FT         = (FALL_THROUGH != 0);
    localparam logic c_PASS_READY = (PASS_READY != 0);
    localparam logic c_ZERO_INV   = (ZERO_INVALID != 0);

    logic [c_PTR_W-1:0]    r_wr_ptr;
    logic [c_PTR_W-1:0]    r_rd_ptr;
    logic [CNT_WIDTH-1:0]  r_count;
    logic                  w_empty;
    logic                  w_full;
    logic                  w_bypass;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_out_valid;
    logic [DATA_WIDTH-1:0] w_out_data;
    logic [DATA_WIDTH-1:0] w_mem_rdata;

    pipe_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (c_PTR_W)
    ) u_mem (
        .clk   (clk),
        .we    (w_push),
        .waddr (r_wr_ptr),
        .wdata (pin_data),
        .raddr (r_rd_ptr),
        .rdata (w_mem_rdata)
    );

    always_comb begin
        w_empty  = (r_count == '0);
        w_full   = (r_count == CNT_WIDTH'(DEPTH));
        // A bypass transfer goes straight through and never touches storage.
        w_bypass = c_FT && w_empty && pin_valid && pout_ready && !flush;

        if (flush)             pin_ready = 1'b0;
        else if (c_PASS_READY) pin_ready = !w_full || pout_ready;
        else                   pin_ready = !w_full;

        if (flush) begin
            w_out_valid = 1'b0;
            w_out_data  = w_mem_rdata;
        end else if (w_empty && c_FT) begin
            w_out_valid = pin_valid;
            w_out_data  = pin_data;
        end else begin
            w_out_valid = !w_empty;
            w_out_data  = w_mem_rdata;
        end

        w_push = pin_valid && pin_ready && !w_bypass;
        w_pop  = w_out_valid && pout_ready && !w_bypass;
    end

    assign pout_valid = w_out_valid;
    assign pout_data  = c_ZERO_INV ? (w_out_data & {DATA_WIDTH{w_out_valid}}) : w_out_data;
    assign count      = r_count;
    assign full       = w_full;
    assign empty      = w_empty;

    always_ff @(posedge clk or negedge rst) begin
        if (rst == c_RST_ACTIVE) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= c_PTR_W'(ptr_next(32'(r_wr_ptr), DEPTH));
            if (w_pop)  r_rd_ptr <= c_PTR_W'(ptr_next(32'(r_rd_ptr), DEPTH));
            r_count <= r_count + CNT_WIDTH'(w_push) - CNT_WIDTH'(w_pop);
        end
    end

`ifndef SYNTHESIS
    a_count_le_depth: assert property (@(posedge clk) disable iff (rst == c_RST_ACTIVE)
        r_count <= CNT_WIDTH'(DEPTH));
    a_push_needs_ready: assert property (@(posedge clk) disable iff (rst == c_RST_ACTIVE)
        w_push |-> pin_ready);
    a_pin_data_stable: assert property (@(posedge clk) disable iff (rst == c_RST_ACTIVE)
        (pin_valid && !pin_ready) |=> $stable(pin_data));
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipe_fifo
//  Brief    : Scoreboard bench over four pipe_fifo configurations.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_fifo;

    logic clk;
    logic rst;
    logic flush_off;
    int   n_checks;
    int   n_errors;

    // d4: DEPTH=4 registered path; d3: DEPTH=3 wrap; ft: fall-through; p0: PASS_READY=0
    logic        d4_v, d4_rdy, d4_ov, d4_pr, d4_flush, d4_full, d4_empty;
    logic [15:0] d4_d, d4_od;
    logic [2:0]  d4_cnt;
    logic        d3_v, d3_rdy, d3_ov, d3_pr, d3_full, d3_empty;
    logic [15:0] d3_d, d3_od;
    logic [1:0]  d3_cnt;
    logic        ft_v, ft_rdy, ft_ov, ft_pr, ft_full, ft_empty;
    logic [15:0] ft_d, ft_od;
    logic [1:0]  ft_cnt;
    logic        p0_v, p0_rdy, p0_ov, p0_pr, p0_full, p0_empty;
    logic [15:0] p0_d, p0_od;
    logic [1:0]  p0_cnt;

    logic [15:0] q_d4[$];
    logic [15:0] q_d3[$];
    logic [15:0] q_ft[$];
    logic [15:0] q_p0[$];

    pipe_fifo #(.DATA_WIDTH(16), .DEPTH(4), .FALL_THROUGH(0), .PASS_READY(1), .ZERO_INVALID(1)) u_d4 (
        .clk(clk), .rst(rst), .flush(d4_flush), .pin_valid(d4_v), .pin_data(d4_d), .pin_ready(d4_rdy),
        .pout_valid(d4_ov), .pout_data(d4_od), .pout_ready(d4_pr), .count(d4_cnt), .full(d4_full), .empty(d4_empty));
    pipe_fifo #(.DATA_WIDTH(16), .DEPTH(3), .FALL_THROUGH(0), .PASS_READY(1), .ZERO_INVALID(1)) u_d3 (
        .clk(clk), .rst(rst), .flush(flush_off), .pin_valid(d3_v), .pin_data(d3_d), .pin_ready(d3_rdy),
        .pout_valid(d3_ov), .pout_data(d3_od), .pout_ready(d3_pr), .count(d3_cnt), .full(d3_full), .empty(d3_empty));
    pipe_fifo #(.DATA_WIDTH(16), .DEPTH(2), .FALL_THROUGH(1), .PASS_READY(1), .ZERO_INVALID(1)) u_ft (
        .clk(clk), .rst(rst), .flush(flush_off), .pin_valid(ft_v), .pin_data(ft_d), .pin_ready(ft_rdy),
        .pout_valid(ft_ov), .pout_data(ft_od), .pout_ready(ft_pr), .count(ft_cnt), .full(ft_full), .empty(ft_empty));
    pipe_fifo #(.DATA_WIDTH(16), .DEPTH(2), .FALL_THROUGH(0), .PASS_READY(0), .ZERO_INVALID(1)) u_p0 (
        .clk(clk), .rst(rst), .flush(flush_off), .pin_valid(p0_v), .pin_data(p0_d), .pin_ready(p0_rdy),
        .pout_valid(p0_ov), .pout_data(p0_od), .pout_ready(p0_pr), .count(p0_cnt), .full(p0_full), .empty(p0_empty));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Scoreboards: accepted inputs are queued, every output transfer pops one.
    always @(negedge clk) begin
        if (rst) begin
            if (d4_v && d4_rdy) q_d4.push_back(d4_d);
            if (d4_ov && d4_pr) begin
                if (q_d4.size() == 0) check("d4_unexpected_out", 32'(d4_od), 32'hDEAD);
                else                  check("d4_out_data", 32'(d4_od), 32'(q_d4.pop_front()));
            end
            if (d3_v && d3_rdy) q_d3.push_back(d3_d);
            if (d3_ov && d3_pr) begin
                if (q_d3.size() == 0) check("d3_unexpected_out", 32'(d3_od), 32'hDEAD);
                else                  check("d3_out_data", 32'(d3_od), 32'(q_d3.pop_front()));
            end
            if (ft_v && ft_rdy) q_ft.push_back(ft_d);
            if (ft_ov && ft_pr) begin
                if (q_ft.size() == 0) check("ft_unexpected_out", 32'(ft_od), 32'hDEAD);
                else                  check("ft_out_data", 32'(ft_od), 32'(q_ft.pop_front()));
            end
            if (p0_v && p0_rdy) q_p0.push_back(p0_d);
            if (p0_ov && p0_pr) begin
                if (q_p0.size() == 0) check("p0_unexpected_out", 32'(p0_od), 32'hDEAD);
                else                  check("p0_out_data", 32'(p0_od), 32'(q_p0.pop_front()));
            end
        end
    end

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        flush_off = 1'b0;
        rst       = 1'b0;
        d4_flush  = 1'b0;
        d4_v = 1'b1; d4_d = 16'h11; d4_pr = 1'b0;
        d3_v = 1'b0; d3_d = 16'h0;  d3_pr = 1'b0;
        ft_v = 1'b0; ft_d = 16'h0;  ft_pr = 1'b0;
        p0_v = 1'b0; p0_d = 16'h0;  p0_pr = 1'b0;

        // Reset held three cycles with upstream already offering data
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_pout_valid", 32'(d4_ov), 32'd0);
        check("rst_pout_data", 32'(d4_od), 32'd0);
        check("rst_count", 32'(d4_cnt), 32'd0);
        check("rst_empty", 32'(d4_empty), 32'd1);
        check("rst_full", 32'(d4_full), 32'd0);
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        check("rel_pin_ready", 32'(d4_rdy), 32'd1);

        // DEPTH=4: fill with downstream stalled, then drain in order
        @(posedge clk); #1 d4_d = 16'h22;
        @(posedge clk); #1 d4_d = 16'h33;
        @(posedge clk); #1 d4_d = 16'h44;
        @(posedge clk); #1 d4_d = 16'h55;
        @(negedge clk);
        check("d4_full_count", 32'(d4_cnt), 32'd4);
        check("d4_full_flag", 32'(d4_full), 32'd1);
        check("d4_full_ready", 32'(d4_rdy), 32'd0);
        check("d4_head", 32'(d4_od), 32'h11);
        @(posedge clk); #1;
        @(negedge clk);
        check("d4_stall_stable", 32'(d4_od), 32'h11);
        check("d4_stall_count", 32'(d4_cnt), 32'd4);
        @(posedge clk); #1 d4_pr = 1'b1;
        @(negedge clk);
        check("d4_full_pass_ready", 32'(d4_rdy), 32'd1);
        @(posedge clk); #1 d4_v = 1'b0;
        @(negedge clk);
        check("d4_pushpop_full_count", 32'(d4_cnt), 32'd4);
        repeat (4) @(posedge clk);
        #1;
        @(negedge clk);
        check("d4_drained_count", 32'(d4_cnt), 32'd0);
        check("d4_drained_empty", 32'(d4_empty), 32'd1);
        check("d4_queue_empty", 32'(q_d4.size()), 32'd0);

        // DEPTH=3 streaming: pointers wrap several times, occupancy stays at one
        d3_pr = 1'b1;
        d3_v  = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            d3_d = 16'(i);
            @(negedge clk);
            if (i > 1) check("d3_stream_count", 32'(d3_cnt), 32'd1);
            @(posedge clk); #1;
        end
        d3_v = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check("d3_final_count", 32'(d3_cnt), 32'd0);
        check("d3_queue_empty", 32'(q_d3.size()), 32'd0);

        // Fall-through: same-cycle bypass when empty, then a stored entry
        ft_v = 1'b1; ft_d = 16'hABCD; ft_pr = 1'b1;
        @(negedge clk);
        check("ft_bypass_valid", 32'(ft_ov), 32'd1);
        check("ft_bypass_data", 32'(ft_od), 32'hABCD);
        @(posedge clk); #1 ft_pr = 1'b0; ft_d = 16'h1234;
        @(negedge clk);
        check("ft_bypass_count", 32'(ft_cnt), 32'd0);
        check("ft_passthru_data", 32'(ft_od), 32'h1234);
        @(posedge clk); #1 ft_v = 1'b0;
        @(negedge clk);
        check("ft_stored_count", 32'(ft_cnt), 32'd1);
        check("ft_stored_data", 32'(ft_od), 32'h1234);
        @(posedge clk); #1 ft_pr = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("ft_final_count", 32'(ft_cnt), 32'd0);

        // PASS_READY=0: full blocks input even with downstream ready
        p0_v = 1'b1; p0_d = 16'hA1;
        @(posedge clk); #1 p0_d = 16'hA2;
        @(posedge clk); #1 p0_d = 16'hA3; p0_pr = 1'b1;
        @(negedge clk);
        check("p0_full_flag", 32'(p0_full), 32'd1);
        check("p0_full_ready", 32'(p0_rdy), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("p0_after_pop_count", 32'(p0_cnt), 32'd1);
        check("p0_after_pop_ready", 32'(p0_rdy), 32'd1);
        @(posedge clk); #1 p0_v = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check("p0_final_count", 32'(p0_cnt), 32'd0);
        check("p0_queue_empty", 32'(q_p0.size()), 32'd0);

        // Flush with three stored entries and a held input
        d4_pr = 1'b0; d4_v = 1'b1; d4_d = 16'h61;
        @(posedge clk); #1 d4_d = 16'h62;
        @(posedge clk); #1 d4_d = 16'h63;
        @(posedge clk); #1 d4_d = 16'h64; d4_flush = 1'b1;
        q_d4.delete();
        @(negedge clk);
        check("fl_count_before", 32'(d4_cnt), 32'd3);
        check("fl_pin_ready", 32'(d4_rdy), 32'd0);
        check("fl_pout_valid", 32'(d4_ov), 32'd0);
        check("fl_pout_data", 32'(d4_od), 32'd0);
        @(posedge clk); #1 d4_flush = 1'b0;
        @(negedge clk);
        check("fl_count_after", 32'(d4_cnt), 32'd0);
        check("fl_empty_after", 32'(d4_empty), 32'd1);
        check("fl_ready_after", 32'(d4_rdy), 32'd1);
        @(posedge clk); #1 d4_v = 1'b0; d4_pr = 1'b1;
        @(negedge clk);
        check("fl_held_valid", 32'(d4_ov), 32'd1);
        check("fl_held_data", 32'(d4_od), 32'h64);
        @(posedge clk); #1;
        @(negedge clk);
        check("fl_final_count", 32'(d4_cnt), 32'd0);

        // Asynchronous reset mid-operation discards entries without a clock
        d3_pr = 1'b0; d3_v = 1'b1; d3_d = 16'h71;
        @(posedge clk); #1 d3_d = 16'h72;
        @(posedge clk); #1 d3_v = 1'b0;
        @(negedge clk);
        check("ar_count_before", 32'(d3_cnt), 32'd2);
        #2 rst = 1'b0;
        #1;
        check("ar_count", 32'(d3_cnt), 32'd0);
        check("ar_empty", 32'(d3_empty), 32'd1);
        check("ar_pout_valid", 32'(d3_ov), 32'd0);
        q_d3.delete();
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        check("ar_ready_after", 32'(d3_rdy), 32'd1);

        check("end_q_d4", 32'(q_d4.size()), 32'd0);
        check("end_q_ft", 32'(q_ft.size()), 32'd0);
        check("end_q_p0", 32'(q_p0.size()), 32'd0);
        check("end_d3_full", 32'(d3_full), 32'd0);
        check("end_ft_flags", 32'({ft_full, ft_empty, ft_rdy}), 32'b011);
        check("end_p0_flags", 32'({p0_empty, p0_ov}), 32'b10);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
